// File: rtl/rr_arb4_enc_pkg.sv
// rr_arb4_enc_pkg: shared constants and state encoding for the round-robin arbiter
package rr_arb4_enc_pkg;
  localparam int NREQ = 4;
  localparam int MAX_HOLD_DEF = 15;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_arb4_enc_enc4to2.sv
// enc4to2: one-hot to binary encoder; bit 0 of the one-hot input never affects the code
module enc4to2 (
  input  logic [3:1] i,
  output logic [1:0] o
);
  assign o = {i[3] | i[2], i[3] | i[1]};
endmodule

// File: rtl/rr_arb4_enc.sv
// rr_arb4_enc: four-way round-robin arbiter with one-hot grant, encoded index and hold limit
module rr_arb4_enc
  import rr_arb4_enc_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      gnt_idx,
  output logic            gnt_vld,
  output logic            timeout
);
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, idx_n;
  logic [CW-1:0] hold_cnt, hold_n;
  logic [NREQ-1:0] rot, pick, win, gnt_n;
  logic limit, normal, rel, to_n;
  // rotate so ptr sits at bit 0, keep the lowest set bit, rotate back
  assign rot = NREQ'({req, req} >> ptr);
  assign pick = rot & (~rot + 4'd1);
  assign win = NREQ'({pick, pick} >> (NREQ - int'(ptr)));
  assign limit = (MAX_HOLD != 0) && (hold_cnt == CW'(MAX_HOLD - 1));
  assign normal = done | ~req[gnt_idx];
  assign rel = normal | limit;
  always_comb begin
    state_n = (state == IDLE) ? ((|req) ? GRANT : IDLE) : (rel ? IDLE : GRANT);
    gnt_n = (state == IDLE) ? win : (rel ? '0 : gnt);
    ptr_n = (state == GRANT && rel) ? gnt_idx + 2'd1 : ptr;
    hold_n = (state == IDLE || rel) ? '0
           : ((MAX_HOLD == 0 && &hold_cnt) ? hold_cnt : hold_cnt + 1'b1);
    to_n = (state == GRANT) && limit && !normal;
  end
  enc4to2 u_enc (.i(gnt_n[3:1]), .o(idx_n));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      gnt <= '0;
      gnt_idx <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      hold_cnt <= hold_n;
      gnt <= gnt_n;
      gnt_idx <= idx_n;
      timeout <= to_n;
    end
  end
  assign gnt_vld = (state == GRANT);
  a_gnt_consistent: assert property (@(posedge clk) disable iff (rst)
    gnt_vld ? (gnt == (4'b0001 << gnt_idx)) : (gnt == '0 && gnt_idx == '0));
endmodule

// File: tb/tb_rr_arb4_enc.sv
// tb_rr_arb4_enc: directed checks of reset, rotation, pointer wrap, request drop, hold limit and async reset
module tb_rr_arb4_enc;
  logic clk = 1'b0, rst = 1'b1, done = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic gnt_vld, timeout;
  int total = 0, bad = 0;

  rr_arb4_enc #(.MAX_HOLD(4), .CW(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    step();
    step();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b want=0000", gnt); end
    total++; if (gnt_idx !== 2'd0) begin bad++; $display("FAIL rst_idx got=%0d want=0", gnt_idx); end
    total++; if (gnt_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b want=0", gnt_vld); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b want=0", timeout); end
    rst = 1'b0;
    step();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL first_gnt got=%b want=0001", gnt); end
    total++; if (gnt_idx !== 2'd0) begin bad++; $display("FAIL first_idx got=%0d want=0", gnt_idx); end
    total++; if (gnt_vld !== 1'b1) begin bad++; $display("FAIL first_vld got=%b want=1", gnt_vld); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL rot_gnt[%0d] got=%b want=%b", i, gnt, exp_g); end
      total++; if (gnt_idx !== 2'(i % 4)) begin bad++; $display("FAIL rot_idx[%0d] got=%0d want=%0d", i, gnt_idx, i % 4); end
      done = 1'b1;
      step();
      done = 1'b0;
      total++; if (gnt_vld !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL rot_gap[%0d] got vld=%b gnt=%b want vld=0 gnt=0000", i, gnt_vld, gnt); end
      step();
    end
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rot_after got=%b want=0010", gnt); end
  endtask

  task automatic test_pointer_skip();
    done = 1'b1;
    req = 4'b0001;
    step();
    done = 1'b0;
    step();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL skip_gnt got=%b want=0001", gnt); end
    total++; if (gnt_idx !== 2'd0) begin bad++; $display("FAIL skip_idx got=%0d want=0", gnt_idx); end
    req = 4'b0000;
    step();
    total++; if (gnt_vld !== 1'b0) begin bad++; $display("FAIL skip_rel got=%b want=0", gnt_vld); end
  endtask

  task automatic test_req_drop();
    req = 4'b0100;
    step();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL drop_gnt got=%b want=0100", gnt); end
    req = 4'b0000;
    step();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL drop_rel got=%b want=0000", gnt); end
    req = 4'b1001;
    step();
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL drop_next got=%b want=1000", gnt); end
    total++; if (gnt_idx !== 2'd3) begin bad++; $display("FAIL drop_idx got=%0d want=3", gnt_idx); end
    req = 4'b0000;
    step();
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL drop_timeout got=%b want=0", timeout); end
  endtask

  task automatic test_hold_limit();
    req = 4'b0100;
    step();
    for (int c = 0; c < 4; c++) begin
      total++; if (gnt !== 4'b0100 || timeout !== 1'b0) begin bad++; $display("FAIL hold_cyc[%0d] got gnt=%b to=%b want gnt=0100 to=0", c, gnt, timeout); end
      step();
    end
    total++; if (gnt !== 4'b0000 || timeout !== 1'b1) begin bad++; $display("FAIL hold_expire got gnt=%b to=%b want gnt=0000 to=1", gnt, timeout); end
    step();
    total++; if (gnt !== 4'b0100 || timeout !== 1'b0) begin bad++; $display("FAIL hold_regrant got gnt=%b to=%b want gnt=0100 to=0", gnt, timeout); end
    step();
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    total++; if (gnt !== 4'b0000 || timeout !== 1'b0) begin bad++; $display("FAIL hold_done_tie got gnt=%b to=%b want gnt=0000 to=0", gnt, timeout); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_async_reset();
    req = 4'b0010;
    step();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL ar_pre got=%b want=0010", gnt); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin bad++; $display("FAIL ar_drop got gnt=%b vld=%b want gnt=0000 vld=0", gnt, gnt_vld); end
    step();
    rst = 1'b0;
    req = 4'b1111;
    step();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL ar_post got=%b want=0001", gnt); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_pointer_skip();
    test_req_drop();
    test_hold_limit();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_arb4_enc.md
Name: rr_arb4_enc

Overview:
- Four-requester round-robin arbiter that shares one downstream resource, such as a bus or datapath slot.
- Grant is one-hot. A binary grant index is derived from it through the team's 4-to-2 encoder.
- Fairness comes from a rotating priority pointer.
- Grant tenure ends on requester release, explicit done, or a hold-time limit.
- Sits between requesting agents and the shared resource mux; gnt_idx drives that mux select.

Parameters:
- MAX_HOLD, 15, maximum consecutive cycles one requester may hold the grant; 0 disables the limit.
- CW, 4, width of the hold counter; must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- req  input  4  request per agent, level; req[i] is agent i.
- done  input  1  current owner signals end of transfer; sampled only in GRANT.
- gnt  output  4  one-hot registered grant; all zeros when idle.
- gnt_idx  output  2  binary index of the granted agent; 0 when gnt_vld=0.
- gnt_vld  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset values (async, while rst=1):
  - gnt=0000, gnt_idx=00, gnt_vld=0, timeout=0.
  - State IDLE, ptr=0, hold_cnt=0.
- There are two states, IDLE and GRANT.
- IDLE:
  - If req!=0, the winner is the first set bit scanning circularly ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At the next edge: gnt=onehot(winner), gnt_idx=winner, gnt_vld=1, hold_cnt=0, state=GRANT.
  - Latency from req sampled high to gnt visible is 1 clock.
  - If req==0, stay in IDLE with outputs at their reset values.
- GRANT, with owner k = gnt_idx:
  - Release conditions: done=1, or req[k]=0, or (MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1).
  - On release, at the next edge: gnt=0000, gnt_idx=00, gnt_vld=0, ptr=(k+1) mod 4, state=IDLE.
  - Otherwise hold_cnt increments and all outputs hold.
- Release priority:
  - If done=1 or req[k]=0 in the same cycle as the hold limit, the release is treated as normal and timeout stays 0.
  - timeout=1 for exactly the cycle after a release caused only by the hold limit.
- Changes to other req bits during GRANT do not affect the current grant.
- Each release is followed by exactly one IDLE cycle with gnt_vld=0 before the next grant. Back-to-back grants are therefore spaced 2 cycles apart minimum.
- Pointer behaviour:
  - ptr wraps 3→0.
  - ptr is not updated when IDLE sees no requests.
- Grant invariants: gnt is always one-hot or zero, and gnt_idx always equals the encoded gnt. The implementation checks this with an assertion.
- Mid-operation reset: rst asserted in GRANT drops the grant immediately (asynchronously) and returns ptr to 0. The first edge after rst deasserts behaves as IDLE.
- Width rules:
  - hold_cnt is CW bits and never wraps in normal operation, because a release occurs at MAX_HOLD-1.
  - With MAX_HOLD=0, hold_cnt saturates at all-ones rather than wrapping.

Decomposition:
- The shared package holds:
  - constant NREQ=4;
  - state encoding IDLE=1'b0, GRANT=1'b1;
  - the default MAX_HOLD.
- One sub-module is natural: enc4to2, a pure gate-level one-hot to binary encoder with o1 = i3|i2 and o0 = i3|i1.
- enc4to2 is instantiated on the next-grant vector so that gnt_idx is registered alongside gnt.
- Winner selection (rotate, priority-pick, rotate back) stays inline in rr_arb4_enc.

Test Plan:
- Reset/idle: hold rst=1 with req=1111, then release rst → on the first edge gnt=0001, gnt_idx=00, gnt_vld=1; during rst all outputs are 0.
- Round-robin rotation: req=1111 held, owners pulse done each grant → grant order is 0,1,2,3,0, each grant separated by one gnt_vld=0 cycle.
- Pointer skip: after agent 1 is released, req=0001 → grant goes to agent 0 (wrap), gnt=0001.
- Release by request drop: agent 2 granted, req[2] falls → the next cycle has gnt=0000, and ptr then favours agent 3 over agent 0 when req=1001 (gnt=1000).
- Hold limit: MAX_HOLD=4, req=0100 held, done=0 → gnt=0100 for exactly 4 cycles, then timeout=1 for 1 cycle with gnt=0000, then re-grant to agent 2.
- Async reset mid-grant: assert rst between edges while gnt=0010 → gnt=0000 and gnt_vld=0 without waiting for a clock edge; after deassert with req=1111 the grant goes to agent 0.
